// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner: rotates an active-low row drive, synchronises the
// columns, debounces whole frames and presents the single held key as one-hot.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] onehot,
  output logic        key_press
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]        col_meta;
  logic [3:0]        col_s;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        row;
  logic [1:0]        row_next;
  logic [15:0]       frame_bits;
  logic              frame_done;
  logic [15:0]       candidate;
  logic [CNT_W-1:0]  stable_cnt;

  logic              slot_end;
  logic              frame_single;
  logic [15:0]       frame_code;
  logic [15:0]       next_cand;
  logic [CNT_W-1:0]  next_cnt;

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign row_next = row + 2'd1;

  // More than one bit set (multi-key or ghosting) is treated as no key.
  always_comb begin
    frame_single = (frame_bits != 16'h0000) &&
                   ((frame_bits & (frame_bits - 16'd1)) == 16'h0000);
    frame_code   = frame_single ? frame_bits : 16'h0000;
  end

  always_comb begin
    next_cand = candidate;
    next_cnt  = stable_cnt;
    if (frame_code != candidate) begin
      next_cand = frame_code;
      next_cnt  = CNT_W'(1);
    end else if (stable_cnt < CNT_FULL) begin
      next_cnt = stable_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta   <= 4'b1111;
      col_s      <= 4'b1111;
      slot_cnt   <= '0;
      row        <= 2'd0;
      row_n      <= 4'b1110;
      frame_bits <= 16'h0000;
      frame_done <= 1'b0;
      candidate  <= 16'h0000;
      stable_cnt <= '0;
      onehot     <= 16'h0000;
      key_press  <= 1'b0;
    end else begin
      col_meta  <= col_n;
      col_s     <= col_meta;
      key_press <= 1'b0;

      // Sample at the end of the slot so the columns have settled after the row change.
      if (slot_end) begin
        slot_cnt                <= '0;
        frame_bits[row*4 +: 4]  <= ~col_s;
        row                     <= row_next;
        row_n                   <= ~(4'b0001 << row_next);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      frame_done <= slot_end && (row == 2'd3);

      if (frame_done) begin
        candidate  <= next_cand;
        stable_cnt <= next_cnt;
        if (next_cnt == CNT_FULL) begin
          onehot    <= next_cand;
          key_press <= (next_cand != 16'h0000) && (next_cand != onehot);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (16-cycle frames, eval edge of frame k at cycle 16k+1 after reset).
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] onehot;
  logic        key_press;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_total = 0;

  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n),
    .row_n(row_n), .onehot(onehot), .key_press(key_press)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
    if (key_press) pulse_total <= pulse_total + 1;
  end

  task automatic do_reset(input logic [15:0] k);
    @(negedge clk);
    rst  = 1'b1;
    keys = k;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc !== n) begin
      failures++;
      $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic test_reset;
    do_reset(16'h0000);
    checks++;
    if (row_n !== 4'b1110) begin failures++; $display("FAIL reset_row_n: got %b expected 1110", row_n); end
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL reset_onehot: got %h expected 0000", onehot); end
    checks++;
    if (key_press !== 1'b0) begin failures++; $display("FAIL reset_key_press: got %b expected 0", key_press); end
  endtask

  task automatic test_scan_idle;
    logic [3:0] exp_row;
    for (int k = 1; k <= 40; k++) begin
      wait_cyc(k);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (row_n !== exp_row) begin failures++; $display("FAIL idle_row_n c%0d: got %b expected %b", k, row_n, exp_row); end
      checks++;
      if (onehot !== 16'h0000 || key_press !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs c%0d: got onehot=%h kp=%b expected 0000/0", k, onehot, key_press);
      end
    end
  endtask

  task automatic test_single_press;
    int p0;
    do_reset(16'h0040);
    p0 = pulse_total;
    wait_cyc(48);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL press_early: got %h expected 0000", onehot); end
    wait_cyc(49);
    checks++;
    if (onehot !== 16'h0040) begin failures++; $display("FAIL press_onehot: got %h expected 0040", onehot); end
    checks++;
    if (key_press !== 1'b1) begin failures++; $display("FAIL press_pulse: got %b expected 1", key_press); end
    wait_cyc(50);
    checks++;
    if (key_press !== 1'b0) begin failures++; $display("FAIL press_pulse_width: got %b expected 0", key_press); end
    wait_cyc(209);
    checks++;
    if (onehot !== 16'h0040) begin failures++; $display("FAIL press_hold: got %h expected 0040", onehot); end
    checks++;
    if (pulse_total - p0 !== 1) begin failures++; $display("FAIL press_pulse_count: got %0d expected 1", pulse_total - p0); end
  endtask

  // Continues from test_single_press: release at cycle 209, first keyless frame is frame 14.
  task automatic test_release;
    int p0;
    keys = 16'h0000;
    p0 = pulse_total;
    wait_cyc(256);
    checks++;
    if (onehot !== 16'h0040) begin failures++; $display("FAIL release_early: got %h expected 0040", onehot); end
    wait_cyc(257);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL release_onehot: got %h expected 0000", onehot); end
    checks++;
    if (key_press !== 1'b0) begin failures++; $display("FAIL release_pulse: got %b expected 0", key_press); end
    wait_cyc(300);
    checks++;
    if (pulse_total - p0 !== 0) begin failures++; $display("FAIL release_pulse_count: got %0d expected 0", pulse_total - p0); end
  endtask

  // Row-1 samples: frame 1 sees released, frame 2 onward pressed -> onehot at eval of frame 4.
  task automatic test_bounce;
    int p0;
    do_reset(16'h0040);
    p0 = pulse_total;
    for (int k = 0; k < 32; k++) begin
      wait_cyc(k);
      keys = (((k / 5) % 2) == 0) ? 16'h0040 : 16'h0000;
    end
    wait_cyc(32);
    keys = 16'h0040;
    wait_cyc(48);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL bounce_mid: got %h expected 0000", onehot); end
    wait_cyc(64);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL bounce_early: got %h expected 0000", onehot); end
    wait_cyc(65);
    checks++;
    if (onehot !== 16'h0040 || key_press !== 1'b1) begin
      failures++;
      $display("FAIL bounce_settle: got onehot=%h kp=%b expected 0040/1", onehot, key_press);
    end
    wait_cyc(120);
    checks++;
    if (pulse_total - p0 !== 1) begin failures++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulse_total - p0); end
  endtask

  task automatic test_multi_key;
    int p0;
    do_reset(16'h0801);
    p0 = pulse_total;
    wait_cyc(100);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL multi_onehot: got %h expected 0000", onehot); end
    checks++;
    if (pulse_total - p0 !== 0) begin failures++; $display("FAIL multi_pulse_count: got %0d expected 0", pulse_total - p0); end
    keys = 16'h0001;
    wait_cyc(144);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL multi_early: got %h expected 0000", onehot); end
    wait_cyc(145);
    checks++;
    if (onehot !== 16'h0001 || key_press !== 1'b1) begin
      failures++;
      $display("FAIL multi_single: got onehot=%h kp=%b expected 0001/1", onehot, key_press);
    end
    wait_cyc(180);
    checks++;
    if (pulse_total - p0 !== 1) begin failures++; $display("FAIL multi_pulse_count2: got %0d expected 1", pulse_total - p0); end
  endtask

  task automatic test_back_to_back;
    int p0;
    do_reset(16'h2000);
    p0 = pulse_total;
    wait_cyc(49);
    checks++;
    if (onehot !== 16'h2000 || key_press !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got onehot=%h kp=%b expected 2000/1", onehot, key_press);
    end
    keys = 16'h1000;
    wait_cyc(96);
    checks++;
    if (onehot !== 16'h2000) begin failures++; $display("FAIL b2b_hold: got %h expected 2000", onehot); end
    wait_cyc(97);
    checks++;
    if (onehot !== 16'h1000 || key_press !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: got onehot=%h kp=%b expected 1000/1", onehot, key_press);
    end
    wait_cyc(98);
    checks++;
    if (pulse_total - p0 !== 2) begin failures++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulse_total - p0); end
  endtask

  task automatic test_reset_mid_slot;
    wait_cyc(102);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (row_n !== 4'b1110 || onehot !== 16'h0000 || key_press !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got row_n=%b onehot=%h kp=%b expected 1110/0000/0", row_n, onehot, key_press);
    end
    rst = 1'b0;
    wait_cyc(48);
    checks++;
    if (onehot !== 16'h0000) begin failures++; $display("FAIL midreset_early: got %h expected 0000", onehot); end
    wait_cyc(49);
    checks++;
    if (onehot !== 16'h1000 || key_press !== 1'b1) begin
      failures++;
      $display("FAIL midreset_rescan: got onehot=%h kp=%b expected 1000/1", onehot, key_press);
    end
  endtask

  initial begin
    test_reset;
    test_scan_idle;
    test_single_press;
    test_release;
    test_bounce;
    test_multi_key;
    test_back_to_back;
    test_reset_mid_slot;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
